// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART controller: FSM state encodings and
// the uart_stat bit positions the CSR unit uses to assemble MUARTSTAT.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int STAT_W        = 6;
    localparam int STAT_RXEMPTY  = 0;
    localparam int STAT_RXFULL   = 1;
    localparam int STAT_TXEMPTY  = 2;
    localparam int STAT_TXFULL   = 3;
    localparam int STAT_OVERRUN  = 4;
    localparam int STAT_FRAMEERR = 5;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO used for both UART directions. Push while full and pop
// while empty are ignored; flags come from the registered count.
module uart_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/uart_ctrl.sv
// 8N1 UART controller: TX/RX FIFOs, serializer, synchronized deserializer
// and sticky error status for the CSR unit.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csr_uart_tx_valid,
    input  logic [7:0]        csr_uart_tx_data,
    input  logic              csr_uart_rx_pop,
    input  logic              csr_uart_err_clr,
    output logic [7:0]        uart_rx_data,
    output logic [STAT_W-1:0] uart_stat,
    output logic              uart_txd,
    input  logic              uart_rxd
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0] tx_head, rx_head;
    logic       tx_empty, tx_full, tx_pop;
    logic       rx_empty, rx_full, rx_push;
    logic [AW:0] tx_count, rx_count;

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push(csr_uart_tx_valid), .push_data(csr_uart_tx_data),
        .pop(tx_pop), .head(tx_head),
        .empty(tx_empty), .full(tx_full), .count(tx_count)
    );

    // ---------------- TX ----------------
    uart_state_e tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;
    logic          tx_bnd;

    assign tx_bnd = (tx_cnt_q == CW'(CLKS_PER_BIT-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            ST_IDLE:  if (!tx_empty) tx_state_d = ST_START;
            ST_START: if (tx_bnd) tx_state_d = ST_DATA;
            ST_DATA:  if (tx_bnd && tx_bit_q == 3'd7) tx_state_d = ST_STOP;
            ST_STOP:  if (tx_bnd) tx_state_d = tx_empty ? ST_IDLE : ST_START;
            default:  tx_state_d = ST_IDLE;
        endcase
    end

    // txd is registered from the current state, so the line trails the FSM
    // by one cycle; every bit still spans exactly CLKS_PER_BIT cycles.
    always_comb begin
        tx_pop     = !tx_empty && (tx_state_q == ST_IDLE || (tx_state_q == ST_STOP && tx_bnd));
        tx_cnt_d   = (tx_state_q == ST_IDLE || tx_bnd) ? '0 : tx_cnt_q + CW'(1);
        tx_bit_d   = (tx_state_q != ST_DATA) ? 3'd0 : (tx_bnd ? tx_bit_q + 3'd1 : tx_bit_q);
        tx_shift_d = tx_shift_q;
        if (tx_pop)
            tx_shift_d = tx_head;
        else if (tx_state_q == ST_DATA && tx_bnd)
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
        case (tx_state_q)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = tx_shift_q[0];
            default:  txd_d = 1'b1;
        endcase
    end

    assign uart_txd = txd_q;

    // ---------------- RX ----------------
    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    uart_state_e rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          overrun_q, overrun_d;
    logic          frameerr_q, frameerr_d;
    logic          rx_half, rx_bnd, frame_bad;

    assign rx_half = (rx_cnt_q == CW'(CLKS_PER_BIT/2 - 1));
    assign rx_bnd  = (rx_cnt_q == CW'(CLKS_PER_BIT-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            overrun_q  <= 1'b0;
            frameerr_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            overrun_q  <= overrun_d;
            frameerr_q <= frameerr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            ST_IDLE:  if (rxd_prev_q && !rxd_sync_q) rx_state_d = ST_START;
            ST_START: if (rx_half) rx_state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
            ST_DATA:  if (rx_bnd && rx_bit_q == 3'd7) rx_state_d = ST_STOP;
            ST_STOP:  if (rx_bnd) rx_state_d = ST_IDLE;
            default:  rx_state_d = ST_IDLE;
        endcase
    end

    // The half-bit wait in START puts every later sample mid-bit.
    always_comb begin
        rx_cnt_d = rx_cnt_q + CW'(1);
        case (rx_state_q)
            ST_IDLE:  rx_cnt_d = '0;
            ST_START: if (rx_half) rx_cnt_d = '0;
            default:  if (rx_bnd) rx_cnt_d = '0;
        endcase
        rx_bit_d   = (rx_state_q != ST_DATA) ? 3'd0 : (rx_bnd ? rx_bit_q + 3'd1 : rx_bit_q);
        rx_shift_d = (rx_state_q == ST_DATA && rx_bnd) ? {rxd_sync_q, rx_shift_q[7:1]} : rx_shift_q;
        rx_push    = (rx_state_q == ST_STOP) && rx_bnd && rxd_sync_q;
        frame_bad  = (rx_state_q == ST_STOP) && rx_bnd && !rxd_sync_q;
        overrun_d  = (rx_push && rx_full) || (overrun_q && !csr_uart_err_clr);
        frameerr_d = frame_bad || (frameerr_q && !csr_uart_err_clr);
    end

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push(rx_push), .push_data(rx_shift_q),
        .pop(csr_uart_rx_pop), .head(rx_head),
        .empty(rx_empty), .full(rx_full), .count(rx_count)
    );

    // ---------------- Status ----------------
    always_comb begin
        uart_stat                = '0;
        uart_stat[STAT_RXEMPTY]  = rx_empty;
        uart_stat[STAT_RXFULL]   = rx_full;
        uart_stat[STAT_TXEMPTY]  = tx_empty && (tx_state_q == ST_IDLE);
        uart_stat[STAT_TXFULL]   = tx_full;
        uart_stat[STAT_OVERRUN]  = overrun_q;
        uart_stat[STAT_FRAMEERR] = frameerr_q;
        uart_rx_data             = rx_empty ? 8'h00 : rx_head;
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl at 4 clocks per bit, 8-entry FIFOs:
// TX frames checked bit-exact, RX bytes checked on pop.
module tb_uart_ctrl;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx_pop = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic [5:0] stat;
    logic       txd;
    logic       rxd;
    logic       rxd_tb = 1'b1;
    logic       loop_en = 1'b0;

    assign rxd = loop_en ? txd : rxd_tb;

    uart_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .csr_uart_tx_valid(tx_valid), .csr_uart_tx_data(tx_data),
        .csr_uart_rx_pop(rx_pop), .csr_uart_err_clr(err_clr),
        .uart_rx_data(rx_data), .uart_stat(stat),
        .uart_txd(txd), .uart_rxd(rxd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         tx_starts[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // TX monitor: captures 40 cycles from each start bit and compares the
    // whole waveform with the expected frame for the next scoreboard byte.
    initial begin
        logic [39:0] obs;
        logic [39:0] expv;
        logic [7:0]  b;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                tx_starts.push_back(cyc);
                obs[0] = txd;
                for (int j = 1; j < 40; j++) begin
                    @(negedge clk);
                    obs[j] = txd;
                end
                if (tx_exp.size() == 0) chk("txspur", 1, 0);
                else begin
                    b = tx_exp.pop_front();
                    for (int j = 0; j < 40; j++)
                        expv[j] = (j < 4) ? 1'b0 : (j < 36) ? b[(j-4)/4] : 1'b1;
                    chk("txframe", obs, expv);
                end
            end
        end
    end

    task automatic send_rx(input logic [7:0] b, input logic stopb, input logic clr);
        for (int j = 0; j < 42; j++) begin
            if (j < 4)       rxd_tb = 1'b0;
            else if (j < 36) rxd_tb = b[(j-4)/4];
            else if (j < 40) rxd_tb = stopb;
            else             rxd_tb = 1'b1;
            err_clr = clr && (j >= 38) && (j <= 40);
            @(negedge clk);
        end
        err_clr = 1'b0;
    endtask

    task automatic pop_rx();
        logic [7:0] e;
        e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'hxx;
        chk("rxdata", rx_data, e);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        int push_cyc;
        int bad;
        int t;
        repeat (3) @(negedge clk);
        chk("rst_stat", stat, 6'h05);
        chk("rst_rxdata", rx_data, 8'h00);
        chk("rst_txd", txd, 1'b1);
        rst = 1'b0;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (stat !== 6'h05 || txd !== 1'b1) bad++;
        end
        chk("idle_hold", bad, 0);

        // Single byte: start-bit latency and TXEMPTY timing
        tx_exp.push_back(8'hA5);
        tx_valid = 1'b1; tx_data = 8'hA5;
        @(posedge clk); #1 push_cyc = cyc;
        @(negedge clk); tx_valid = 1'b0;
        while (cyc < push_cyc + 40) @(negedge clk);
        chk("txempty_busy", stat[2], 1'b0);
        @(negedge clk);
        chk("txempty_done", stat[2], 1'b1);
        repeat (5) @(negedge clk);
        if (tx_starts.size() > 0) chk("txlat", tx_starts.pop_front(), push_cyc + 2);
        else                      chk("txlat", 0, 1);

        // Burst of 11 pushes: 9 accepted (one popped immediately), 2 dropped
        tx_starts.delete();
        for (int i = 0; i < 11; i++) begin
            tx_valid = 1'b1; tx_data = 8'h10 + 8'(i);
            if (i < 9) tx_exp.push_back(8'h10 + 8'(i));
            @(negedge clk);
            if (i == 7) chk("txnotfull", stat[3], 1'b0);
            if (i == 8) chk("txfull", stat[3], 1'b1);
        end
        tx_valid = 1'b0;
        t = 0;
        while ((tx_exp.size() > 0 || stat[2] !== 1'b1) && t < 600) begin
            @(negedge clk); t++;
        end
        repeat (50) @(negedge clk);
        chk("txdrain", tx_exp.size(), 0);
        chk("txcount", tx_starts.size(), 9);
        bad = 0;
        for (int k = 1; k < tx_starts.size(); k++)
            if (tx_starts[k] - tx_starts[k-1] != 40) bad++;
        chk("txgap", bad, 0);

        // Loopback 8'h3C
        loop_en = 1'b1;
        tx_exp.push_back(8'h3C);
        rx_exp.push_back(8'h3C);
        tx_valid = 1'b1; tx_data = 8'h3C;
        @(negedge clk); tx_valid = 1'b0;
        t = 0;
        while (stat[0] !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        chk("rx_nonempty", stat[0], 1'b0);
        repeat (10) @(negedge clk);
        loop_en = 1'b0;
        pop_rx();
        chk("rx_popped_empty", stat[0], 1'b1);
        chk("rxdata_empty", rx_data, 8'h00);

        // Overflow: 9 frames, no pops
        for (int i = 0; i < 9; i++) begin
            send_rx(8'h41 + 8'(i), 1'b1, 1'b0);
            if (i < 8) rx_exp.push_back(8'h41 + 8'(i));
        end
        chk("rxfull", stat[1], 1'b1);
        chk("overrun", stat[4], 1'b1);
        chk("rxhead_kept", rx_data, rx_exp[0]);
        send_rx(8'h7E, 1'b1, 1'b1);
        chk("overrun_set_wins", stat[4], 1'b1);
        chk("rxhead_kept2", rx_data, rx_exp[0]);
        pulse_clr();
        chk("overrun_clr", stat[4], 1'b0);
        while (rx_exp.size() > 0) pop_rx();
        chk("rx_drained", stat[0], 1'b1);

        // Framing error, then a one-cycle glitch, then a clean frame
        send_rx(8'h55, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("frameerr", stat[5], 1'b1);
        chk("fe_nopush", stat[0], 1'b1);
        pulse_clr();
        chk("frameerr_clr", stat[5], 1'b0);
        rxd_tb = 1'b0;
        @(negedge clk);
        rxd_tb = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_stat", stat, 6'h05);
        chk("glitch_rxdata", rx_data, 8'h00);
        rx_exp.push_back(8'h96);
        send_rx(8'h96, 1'b1, 1'b0);
        chk("post_glitch_nonempty", stat[0], 1'b0);
        pop_rx();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

UART controller behind the CSR unit's MUARTSTAT/MUARTRX/MUARTTX registers. It replaces the current tie-off status with real transmit and receive FIFOs, an 8N1 serializer and deserializer, and live status bits. The CSR unit pushes TX bytes, pops RX bytes and reads status through a simple valid/ready-style port. The block drives the board-level serial pins directly.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200); minimum 4.
- FIFO_DEPTH, 8: entries per FIFO; power of two, at least 2.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- csr_uart_tx_valid  in  1  push csr_uart_tx_data into the TX FIFO
- csr_uart_tx_data  in  8  byte to transmit
- csr_uart_rx_pop  in  1  pop the RX FIFO head
- csr_uart_err_clr  in  1  clear the sticky error bits
- uart_rx_data  out  8  RX FIFO head; 8'h00 when empty
- uart_stat  out  6  [0] RXEMPTY, [1] RXFULL, [2] TXEMPTY, [3] TXFULL, [4] OVERRUN, [5] FRAMEERR
- uart_txd  out  1  serial out; idle high
- uart_rxd  in  1  serial in; asynchronous

## Operation
TX FIFO:
- A push while TXFULL is dropped.
- TXFULL is computed from the registered count, so a push on a full FIFO is refused even if a pop happens in the same cycle.

TX FSM (states IDLE, START, DATA, STOP):
- IDLE with the FIFO non-empty: pop the head into the shift register and go to START.
- START drives 0, DATA drives 8 bits LSB first, STOP drives 1. Each state lasts CLKS_PER_BIT cycles.
- After STOP, go directly to START if the FIFO is non-empty, otherwise to IDLE.
- uart_txd is registered.
- TXEMPTY = FIFO empty AND FSM in IDLE.

RX input:
- uart_rxd passes through a 2-flop synchronizer before any use.

RX FSM (states IDLE, START, DATA, STOP):
- IDLE: a synchronized falling edge moves to START.
- START: wait CLKS_PER_BIT/2 cycles (integer division). If the line is high, return to IDLE (false start, nothing recorded). Otherwise go to DATA.
- DATA: sample 8 bits at CLKS_PER_BIT intervals, so each sample lands mid-bit. Bits shift in LSB first.
- STOP: sample once more after CLKS_PER_BIT cycles. If high, push the byte. If low, set FRAMEERR and discard the byte. Either way, go to IDLE.

RX FIFO:
- A push while RXFULL drops the byte and sets OVERRUN. The existing contents are unchanged.
- A pop while RXEMPTY is ignored.
- A push and a pop in the same cycle on a non-empty, non-full FIFO both take effect; the count is unchanged.

Error bits:
- OVERRUN and FRAMEERR are sticky until csr_uart_err_clr.
- If a set and a clear occur in the same cycle, the set wins.

Counters and pointers:
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Counts are log2(FIFO_DEPTH)+1 bits.
- The baud counter counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.

## Timing
Reset values:
- uart_txd=1; both FSMs in IDLE; both FIFOs empty; sticky bits 0.
- uart_stat=6'b000101; uart_rx_data=8'h00.
- Reset mid-frame aborts immediately: txd returns high the cycle after rst is sampled, and any partial RX byte is lost.

Status and data visibility:
- A push or pop at edge N is reflected in uart_stat and uart_rx_data from cycle N+1.
- uart_stat and uart_rx_data are combinational from registered state, with no added latency.

TX:
- A push into an empty FIFO with the FSM idle at edge N: the pop happens at N+1 and txd falls at N+2.
- A frame lasts exactly 10×CLKS_PER_BIT cycles.
- Back-to-back frames have no idle gap.

RX:
- A received byte appears in the FIFO (RXEMPTY=0) at most 2 + 9.5×CLKS_PER_BIT + 2 cycles after the falling start edge at the pin.

## Structure
- Shared package/header (rtldefs): FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3) and uart_stat bit indices. The CSR unit uses the bit indices to build MUARTSTAT.
- Sub-module uart_fifo, parameterized on width and depth, instantiated twice (TX and RX). It provides push, pop, head, empty, full and count. The TX and RX FSMs, synchronizer and baud counters live in uart_ctrl.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=8.
- Reset then idle: uart_stat=6'h05 and txd=1 held for 100 cycles.
- Push 8'hA5 once: txd pattern 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, starting 2 cycles after the push. TXEMPTY reasserts after 40 cycles.
- Push 9 bytes back-to-back: TXFULL asserts after the 8th buffered byte. Pushes while full are dropped. Frames are contiguous and the transmitted byte count equals the accepted count.
- Loop txd to rxd and send 8'h3C: RX FIFO head = 8'h3C, RXEMPTY=0. Pop → RXEMPTY=1 and uart_rx_data=8'h00.
- Drive 9 frames into rxd with no pops: RXFULL=1, OVERRUN=1, head equals the first byte. Assert err_clr in the same cycle as a further overflow push → OVERRUN stays 1.
- Drive a frame with stop bit 0 → FRAMEERR=1, no push. Drive a 1-cycle low glitch → no state change.
